// File: rtl/recibir_comando_pkg.sv
// recibir_comando_pkg: baud constants, FSM encodings and ASCII codes shared by the command receiver.
package recibir_comando_pkg;
  localparam int B9600   = 5208;
  localparam int B19200  = 2604;
  localparam int B57600  = 868;
  localparam int B115200 = 434;
  typedef enum logic [1:0] {IDLE, HDR, LEN, PAYLOAD} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_P     = 8'h50;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_O     = 8'h4F;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_R     = 8'h52;
  function automatic logic [7:0] hdr_char(input logic [2:0] i);
    return i == 3'd0 ? ASC_PLUS : i == 3'd1 ? ASC_I : i == 3'd2 ? ASC_P : i == 3'd3 ? ASC_D : ASC_COMMA;
  endfunction
  function automatic logic [7:0] st_char(input logic sel, input logic [2:0] i);
    return !sel ? (i == 3'd0 ? ASC_O : i == 3'd1 ? ASC_K : i == 3'd2 ? ASC_CR : ASC_LF)
                : (i == 3'd0 ? ASC_E : i == 3'd3 ? ASC_O : i == 3'd5 ? ASC_CR : i == 3'd6 ? ASC_LF : ASC_R);
  endfunction
  function automatic logic is_digit(input logic [7:0] b);
    return b >= ASC_0 && b <= ASC_9;
  endfunction
endpackage

// File: rtl/recibir_comando_uart.sv
// uart_rx: 8N1 receiver, 2-FF synchronizer, start check at BAUD/2, LSB first; rcv strobes every byte, ferr flags a low stop bit.
module uart_rx
  import recibir_comando_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr
);
  localparam logic [15:0] HALF = 16'(BAUD / 2);
  localparam logic [15:0] FULL = 16'(BAUD);
  rx_state_t   st, st_n;
  logic [2:0]  sync;
  logic [15:0] tick, tick_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  data_n;
  logic        rcv_n, ferr_n, rx_s;
  assign rx_s = sync[1];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync    <= '1;
      st      <= RX_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      data    <= '0;
      rcv     <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      sync    <= {sync[1:0], rx};
      st      <= st_n;
      tick    <= tick_n;
      bit_cnt <= bit_cnt_n;
      data    <= data_n;
      rcv     <= rcv_n;
      ferr    <= ferr_n;
    end
  always_comb begin
    st_n      = st;
    tick_n    = tick + 16'd1;
    bit_cnt_n = bit_cnt;
    data_n    = data;
    rcv_n     = 1'b0;
    ferr_n    = 1'b0;
    case (st)
      RX_IDLE: begin
        tick_n = '0;
        st_n   = (sync[2] && !rx_s) ? RX_START : RX_IDLE;
      end
      RX_START:
        if (tick == HALF - 16'd1) begin
          tick_n    = '0;
          bit_cnt_n = '0;
          st_n      = rx_s ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (tick == FULL - 16'd1) begin
          tick_n    = '0;
          data_n    = {rx_s, data[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          st_n      = bit_cnt == 3'd7 ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (tick == FULL - 16'd1) begin
          tick_n = '0;
          rcv_n  = 1'b1;
          ferr_n = !rx_s;
          st_n   = RX_IDLE;
        end
      default: st_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/recibir_comando.sv
// recibir_comando: parses +IPD frames carrying a digit command and OK or ERROR status lines from a UART.
module recibir_comando
  import recibir_comando_pkg::*;
#(
  parameter int          BAUD        = B115200,
  parameter logic [27:0] TIMEOUT_CYC = 28'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] comm_out,
  output logic       comm_valid,
  output logic       ok_seen,
  output logic       err_seen,
  output logic       fmt_err,
  output logic       bussy_r
);
  state_t      state, state_n;
  logic [7:0]  data, len, len_n, cnt, cnt_n, comm_out_n;
  logic [2:0]  hdr_idx, hdr_idx_n, st_idx, st_idx_n;
  logic        rcv, ferr, strobe, timeout, in_frame;
  logic        st_sel, st_sel_n, first, first_n;
  logic        comm_valid_n, ok_n, err_n, fmt_n, bussy_n;
  logic [11:0] len_calc;
  uart_rx #(.BAUD(BAUD)) u_rx (
    .clk (clk),
    .rstn(rst),
    .rx  (rx),
    .data(data),
    .rcv (rcv),
    .ferr(ferr)
  );
  assign strobe   = rcv && !ferr;
  assign in_frame = state == LEN || state == PAYLOAD;
  assign len_calc = {4'd0, len} * 12'd10 + {8'd0, data[3:0]};
`ifdef RX_TIMEOUT_EN
  logic [27:0] tmo;
  assign timeout = in_frame && !strobe && tmo == TIMEOUT_CYC - 28'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tmo <= '0;
    else tmo <= (in_frame && !strobe) ? tmo + 28'd1 : '0;
`else
  assign timeout = 1'b0 & |TIMEOUT_CYC;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      hdr_idx    <= '0;
      st_idx     <= '0;
      st_sel     <= 1'b0;
      len        <= '0;
      cnt        <= '0;
      first      <= 1'b0;
      comm_out   <= '0;
      comm_valid <= 1'b0;
      ok_seen    <= 1'b0;
      err_seen   <= 1'b0;
      fmt_err    <= 1'b0;
      bussy_r    <= 1'b0;
    end else begin
      state      <= state_n;
      hdr_idx    <= hdr_idx_n;
      st_idx     <= st_idx_n;
      st_sel     <= st_sel_n;
      len        <= len_n;
      cnt        <= cnt_n;
      first      <= first_n;
      comm_out   <= comm_out_n;
      comm_valid <= comm_valid_n;
      ok_seen    <= ok_n;
      err_seen   <= err_n;
      fmt_err    <= fmt_n;
      bussy_r    <= bussy_n;
    end
  always_comb begin
    state_n      = state;
    hdr_idx_n    = hdr_idx;
    st_idx_n     = in_frame ? 3'd0 : st_idx;
    st_sel_n     = st_sel;
    len_n        = len;
    cnt_n        = cnt;
    first_n      = first;
    comm_out_n   = comm_out;
    comm_valid_n = 1'b0;
    ok_n         = 1'b0;
    err_n        = 1'b0;
    fmt_n        = 1'b0;
    bussy_n      = bussy_r;
    if (strobe)
      case (state)
        IDLE, HDR: begin
          if (data == hdr_char(hdr_idx)) begin
            hdr_idx_n = hdr_idx == 3'd4 ? 3'd0 : hdr_idx + 3'd1;
            state_n   = hdr_idx == 3'd4 ? LEN : HDR;
            len_n     = '0;
            bussy_n   = hdr_idx == 3'd4;
          end else begin
            hdr_idx_n = data == ASC_PLUS ? 3'd1 : 3'd0;
            state_n   = data == ASC_PLUS ? HDR : IDLE;
          end
          if (st_idx != 3'd0 && data == st_char(st_sel, st_idx)) begin
            ok_n     = data == ASC_LF && !st_sel;
            err_n    = data == ASC_LF && st_sel;
            st_idx_n = data == ASC_LF ? 3'd0 : st_idx + 3'd1;
          end else begin
            st_sel_n = data == ASC_E;
            st_idx_n = (data == ASC_O || data == ASC_E) ? 3'd1 : 3'd0;
          end
        end
        LEN:
          if (is_digit(data)) len_n = len_calc > 12'd255 ? 8'd255 : len_calc[7:0];
          else if (data == ASC_COLON && len != 8'd0) begin
            state_n = PAYLOAD;
            cnt_n   = len;
            first_n = 1'b1;
          end else begin
            fmt_n   = 1'b1;
            state_n = IDLE;
            bussy_n = 1'b0;
          end
        PAYLOAD: begin
          comm_out_n   = (first && is_digit(data)) ? data - ASC_0 : comm_out;
          comm_valid_n = first && is_digit(data);
          fmt_n        = first && !is_digit(data);
          first_n      = 1'b0;
          cnt_n        = cnt - 8'd1;
          state_n      = cnt == 8'd1 ? IDLE : PAYLOAD;
          bussy_n      = cnt != 8'd1;
        end
        default: state_n = IDLE;
      endcase
    if (timeout) begin
      fmt_n   = 1'b1;
      state_n = IDLE;
      bussy_n = 1'b0;
      len_n   = '0;
      cnt_n   = '0;
    end
  end
endmodule

// File: tb/tb_recibir_comando.sv
// tb_recibir_comando: directed UART frames with a scoreboard of expected output pulses; baud scaled down to keep runs short.
module tb_recibir_comando;
   localparam int          BAUD = 64;
   localparam logic [27:0] TMO  = 28'd5000;
   localparam int EV_VAL = 0, EV_OK = 1, EV_ERR = 2, EV_FMT = 3;
   typedef struct {int kind; logic [7:0] val;} ev_t;
   logic       clk = 1'b0, rst = 1'b0, rx = 1'b1;
   logic [7:0] comm_out;
   logic       comm_valid, ok_seen, err_seen, fmt_err, bussy_r;
   ev_t        exp_q[$];
   int         checks = 0, failures = 0, cyc = 0, last_strobe = 0;
   recibir_comando #(.BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .comm_out  (comm_out),
      .comm_valid(comm_valid),
      .ok_seen   (ok_seen),
      .err_seen  (err_seen),
      .fmt_err   (fmt_err),
      .bussy_r   (bussy_r)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dut.strobe) last_strobe <= cyc + 1;
   end
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   task automatic expect_ev(input int kind, input logic [7:0] val);
      exp_q.push_back('{kind, val});
   endtask
   task automatic observe(input int kind, input logic [7:0] val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_pulse actual kind=%0d val=%0d required none", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == EV_VAL && e.val != val)) begin
            failures++;
            $display("FAIL pulse actual kind=%0d val=%0d required kind=%0d val=%0d", kind, val, e.kind, e.val);
         end
      end
   endtask
   always @(negedge clk)
      if (rst) begin
         if (comm_valid) observe(EV_VAL, comm_out);
         if (ok_seen) observe(EV_OK, 8'd0);
         if (err_seen) observe(EV_ERR, 8'd0);
         if (fmt_err) observe(EV_FMT, 8'd0);
      end
   task automatic send_byte(input logic [7:0] b, input logic good_stop = 1'b1);
      rx = 1'b0;
      repeat (BAUD) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BAUD) @(posedge clk);
      end
      rx = good_stop;
      repeat (BAUD) @(posedge clk);
      rx = 1'b1;
      repeat (good_stop ? 4 : 2 * BAUD) @(posedge clk);
   endtask
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask
   task automatic send_crlf();
      send_byte(8'h0D);
      send_byte(8'h0A);
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_comm_out"}, comm_out, 0);
      chk({tag, "_comm_valid"}, comm_valid, 0);
      chk({tag, "_ok_seen"}, ok_seen, 0);
      chk({tag, "_err_seen"}, err_seen, 0);
      chk({tag, "_fmt_err"}, fmt_err, 0);
      chk({tag, "_bussy_r"}, bussy_r, 0);
   endtask
   initial begin
      #1500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (5) @(posedge clk);
      #1 chk_all_zero("reset");
      rst = 1'b1;
      repeat (4) @(posedge clk);
      // basic frame, busy held across the length and payload
      expect_ev(EV_VAL, 8'd7);
      send_str("+IPD,");
      chk("busy_in_frame", bussy_r, 1);
      send_str("1:7");
      chk("comm_out_7", comm_out, 7);
      chk("busy_after_7", bussy_r, 0);
      // "OK" inside the payload must not reach the status matcher
      expect_ev(EV_VAL, 8'd4);
      send_str("+IPD,3:4OK");
      chk("comm_out_4", comm_out, 4);
      chk("busy_after_K", bussy_r, 0);
      // double '+' restart, then status lines
      expect_ev(EV_VAL, 8'd2);
      send_str("++IPD,1:2");
      chk("comm_out_2", comm_out, 2);
      expect_ev(EV_OK, 8'd0);
      send_str("OK");
      send_crlf();
      expect_ev(EV_ERR, 8'd0);
      send_str("ERROR");
      send_crlf();
      // malformed frames
      expect_ev(EV_FMT, 8'd0);
      send_str("+IPD,0:");
      chk("busy_after_len0", bussy_r, 0);
      expect_ev(EV_FMT, 8'd0);
      send_str("+IPD,1:A");
      chk("comm_out_kept", comm_out, 2);
      chk("busy_after_A", bussy_r, 0);
      // a byte with a low stop bit is dropped without disturbing the matcher
      expect_ev(EV_OK, 8'd0);
      send_str("OK");
      send_byte(8'h0D);
      send_byte(8'h0A, 1'b0);
      send_byte(8'h0A);
`ifdef RX_TIMEOUT_EN
      expect_ev(EV_FMT, 8'd0);
      send_str("+IPD,2:");
      for (int i = 0; i < 2 * int'(TMO) && !fmt_err; i++) @(negedge clk);
      chk("timeout_delay", cyc - last_strobe, int'(TMO));
      chk("busy_after_timeout", bussy_r, 0);
`else
      expect_ev(EV_VAL, 8'd9);
      send_str("+IPD,2:");
      repeat (int'(TMO) + 1000) @(posedge clk);
      chk("busy_held_truncated", bussy_r, 1);
      send_str("9x");
      chk("comm_out_9", comm_out, 9);
      chk("busy_after_completion", bussy_r, 0);
`endif
      // reset in the middle of the ',' byte
      send_str("+IPD");
      rx = 1'b0;
      repeat (3 * BAUD) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk_all_zero("midreset");
      rx = 1'b1;
      repeat (2 * BAUD) @(posedge clk);
      rst = 1'b1;
      repeat (BAUD) @(posedge clk);
      expect_ev(EV_VAL, 8'd5);
      send_str("+IPD,1:5");
      chk("comm_out_5", comm_out, 5);
      chk("busy_after_5", bussy_r, 0);
      repeat (20) @(posedge clk);
      chk("pending_events", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/recibir_comando.md
RECIBIR_COMANDO -- requirements
Module: recibir_comando

Interface
REQ-001 SHALL have parameter BAUD, default 434 (115200 bd at 50 MHz clk), meaning clocks per UART bit, passed to uart_rx.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 28'd5_000_000, meaning the inter-byte timeout in clk cycles (used only with RX_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  UART serial line from the WiFi module, idle high.
REQ-006 SHALL have port comm_out  output  8  last received command value, 0..9.
REQ-007 SHALL have port comm_valid  output  1  one-cycle pulse when comm_out is updated.
REQ-008 SHALL have port ok_seen  output  1  one-cycle pulse on a complete "OK\r\n".
REQ-009 SHALL have port err_seen  output  1  one-cycle pulse on a complete "ERROR\r\n".
REQ-010 SHALL have port fmt_err  output  1  one-cycle pulse on a malformed +IPD frame or timeout.
REQ-011 SHALL have port bussy_r  output  1  high while an +IPD frame is being parsed.

Function
REQ-012 SHALL act only on the single-cycle byte strobe rcv from uart_rx; every output pulse SHALL occur on the clk edge after the rcv cycle that completes it.
REQ-013 SHALL use FSM states IDLE, HDR, LEN, PAYLOAD; reset state SHALL be IDLE.
REQ-014 IDLE/HDR: match "+IPD," byte by byte; on mismatch, index -> 1 if byte is '+', else 0; after ',' -> LEN with len=0 and bussy_r=1.
REQ-015 LEN: a '0'..'9' byte sets len = len*10 + digit, saturating at 255; ':' with len>0 -> PAYLOAD with cnt=len; ':' with len=0, or any other byte -> fmt_err pulse, IDLE.
REQ-016 PAYLOAD first byte: '0'..'9' sets comm_out = byte-8'h30 and pulses comm_valid; any other byte pulses fmt_err and leaves comm_out unchanged; parsing continues in both cases.
REQ-017 PAYLOAD: each byte decrements cnt, and bytes after the first are discarded; on cnt reaching 0 -> IDLE and bussy_r=0 in the same cycle.
REQ-018 Status matcher ("OK\r\n", "ERROR\r\n") SHALL run in IDLE and HDR only, independently of the +IPD matcher; a mismatch restarts it with the same first-char rule as REQ-014.
REQ-019 Status matcher SHALL be frozen and cleared in LEN and PAYLOAD, so "OK" inside a payload never pulses ok_seen.
REQ-020 A uart_rx framing error (stop bit 0) SHALL discard the byte; no state change results.

Reset
REQ-021 rst low SHALL force IDLE and clear all matchers, len and cnt immediately; comm_out=0, comm_valid=0, ok_seen=0, err_seen=0, fmt_err=0, bussy_r=0.
REQ-022 Reset mid-frame SHALL abandon the frame with no pulse; a byte in flight in uart_rx SHALL be lost.

Configuration
REQ-023 Macro RX_TIMEOUT_EN defined: a 28-bit counter SHALL clear on every rcv and increment otherwise while in LEN or PAYLOAD; at TIMEOUT_CYC it SHALL pulse fmt_err and force IDLE, bussy_r=0.
REQ-024 Macro RX_TIMEOUT_EN undefined: no counter exists, and a truncated frame holds bussy_r high until the next bytes complete it, or until reset.

Structure
REQ-025 Shared package/header SHALL hold the B* baud constants, the FSM state encodings, and the ASCII constants ('+', ':', '0', CR, LF).
REQ-026 Bit sampling SHALL sit in sub-module uart_rx (ports clk, rstn, rx, data[7:0], rcv, ferr): a 2-FF synchronizer, start-bit check at BAUD/2, and 8 data bits LSB first.

Verification
REQ-027 Bench SHALL cover: bytes "+IPD,1:7" at 115200 -> comm_valid one pulse, comm_out=7, bussy_r low after the '7' strobe.
REQ-028 Bench SHALL cover: "+IPD,3:4OK" -> comm_out=4, ok_seen never pulses, IDLE after the 'K'.
REQ-029 Bench SHALL cover: "++IPD,1:2" then "OK\r\n" -> comm_out=2, then one ok_seen pulse; "ERROR\r\n" -> one err_seen pulse.
REQ-030 Bench SHALL cover: "+IPD,0:" -> fmt_err pulse; "+IPD,1:A" -> fmt_err pulse, comm_out unchanged.
REQ-031 Bench SHALL cover, with RX_TIMEOUT_EN: "+IPD,2:" and then silence -> fmt_err exactly TIMEOUT_CYC cycles after the ':' strobe, bussy_r=0.
REQ-032 Bench SHALL cover: rst asserted during the ',' of "+IPD," -> all outputs 0 immediately; a following "+IPD,1:5" -> comm_out=5.
